dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter and sequencer for the byte-addressed data memory. Port 0 carries CPU load/store traffic and port 1 carries a loader/DMA/debug master. The arbiter serialises the two ports onto the single memory port with round-robin fairness, checks size, alignment and range, and returns registered read data with a one-cycle ack. It sits between the requesters and the memory's addr/write_data/mem_write/mem_read/func3/data_out interface.

## Interface
- MEM_BYTES, 1024: memory size in bytes; used for range checking.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- pN_req  in  1  request from port N (N = 0, 1); held high until pN_ack.
- pN_we  in  1  1 = store, 0 = load.
- pN_addr  in  32  byte address.
- pN_wdata  in  32  store data, right-aligned.
- pN_func3  in  3  RISC-V width code.
- pN_ack  out  1  one-cycle completion pulse.
- pN_rdata  out  32  load result; valid while pN_ack = 1.
- pN_err  out  1  access rejected; valid while pN_ack = 1.
- mem_addr  out  32  to memory address.
- mem_write_data  out  32  to memory write data.
- mem_write  out  1  memory write strobe.
- mem_read  out  1  memory read enable.
- mem_func3  out  3  memory width code.
- mem_data_out  in  32  memory combinational read data.

## Operation
- FSM has three states: IDLE, ACCESS, RESP.
- **IDLE**
  - No request: stay in IDLE.
  - Any request: grant a port, latch its we/addr/wdata/func3 and the error check into internal registers, then go to ACCESS.
  - Grant rule: a single requester wins. If both request, grant the port that is not last_grant, then set last_grant to the granted port.
- **ACCESS**
  - Exactly one cycle.
  - If no error: drive mem_addr, mem_write_data and mem_func3 from the latched registers. Assert mem_write = 1 for a store, or mem_read = 1 for a load; never both.
  - A load captures mem_data_out into the granted port's rdata register at the end of this cycle.
  - If error: both strobes stay 0.
  - Next state: RESP.
- **RESP**
  - Granted port sees ack = 1 with err and rdata valid.
  - rdata = 0 for stores and for errored accesses.
  - Next state: IDLE.
- Error conditions:
  - Loads: func3 ∈ {3, 6, 7}.
  - Stores: func3 ∉ {0, 1, 2}.
  - Alignment: LW/SW need addr[1:0] = 0; LH/LHU/SH need addr[0] = 0.
  - Range: addr + size > MEM_BYTES, with size = 1, 2 or 4. Compute in 33 bits so wrap near 2^32 is flagged.
- Width codes: LB = 0, LH = 1, LW = 2, LBU = 4, LHU = 5; SB = 0, SH = 1, SW = 2.
- Outside ACCESS: all mem_* outputs are 0.
- Requests are sampled only in IDLE. Request-field changes after grant are ignored.

## Timing
- Reset values:
  - state = IDLE, last_grant = 1, so port 0 wins the first tie.
  - p0/p1 ack, err and rdata = 0.
  - All mem_* outputs = 0.
- Reset asserted during ACCESS drops mem_write asynchronously. The store may or may not be committed; no ack is issued.
- Latency: request seen in IDLE at cycle T; ACCESS at T+1; ack at T+2. Throughput is one transaction per 3 cycles.
- Handshake:
  - The requester deasserts req on the edge that ends its ack cycle.
  - A req still high in the IDLE after RESP is a new request.
- The ack of one port never coincides with the ack of the other.
- Ties alternate strictly, so a continuously requesting port waits at most one transaction.
- A loser's request stays pending and is granted in the next IDLE.
- The store commits on the rising edge that ends ACCESS, so a load issued right after it sees the new data.

## Test plan
- **Reset then single SW.** Port 0 SW addr 0x10, wdata 0xDEADBEEF → mem_write = 1 for exactly one cycle with mem_addr = 0x10; p0_ack at T+2 with err = 0. A following LW 0x10 returns p0_rdata = 0xDEADBEEF.
- **Sign/zero extension.** SB 0x20 = 0x80, then LB 0x20 → rdata 0xFFFFFF80 and LBU 0x20 → 0x00000080. SH 0x22 = 0x8001, then LH → 0xFFFF8001 and LHU → 0x00008001.
- **Arbitration.** p0_req and p1_req asserted together from reset and held → grants 0, 1, 0, 1. Each ack is 3 cycles apart and acks never overlap.
- **Errors.**
  - LW 0x12 → err = 1, rdata = 0, no mem strobe.
  - SW 0x3FE (MEM_BYTES = 1024) → err = 1, no write.
  - Load func3 = 3 → err = 1.
  - SW 0xFFFFFFFC → err = 1 (33-bit wrap check).
- **Reset mid-operation.** Assert rst during ACCESS of a port-1 store → mem_write goes 0 immediately, no p1_ack, and state is IDLE after release. A new p0 request is then served normally.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Bundle of the two requester ports and the single data-memory port.
// slave: the arbiter's view; master: the requesters/memory side.
interface dmem_arbiter_if;
  logic        p0_req, p0_we, p0_ack, p0_err;
  logic [31:0] p0_addr, p0_wdata, p0_rdata;
  logic [2:0]  p0_func3;
  logic        p1_req, p1_we, p1_ack, p1_err;
  logic [31:0] p1_addr, p1_wdata, p1_rdata;
  logic [2:0]  p1_func3;
  logic [31:0] mem_addr, mem_write_data, mem_data_out;
  logic        mem_write, mem_read;
  logic [2:0]  mem_func3;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata, p0_func3,
    output p0_ack, p0_rdata, p0_err,
    input  p1_req, p1_we, p1_addr, p1_wdata, p1_func3,
    output p1_ack, p1_rdata, p1_err,
    output mem_addr, mem_write_data, mem_write, mem_read, mem_func3,
    input  mem_data_out
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata, p0_func3,
    input  p0_ack, p0_rdata, p0_err,
    output p1_req, p1_we, p1_addr, p1_wdata, p1_func3,
    input  p1_ack, p1_rdata, p1_err,
    input  mem_addr, mem_write_data, mem_write, mem_read, mem_func3,
    output mem_data_out
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter/sequencer for the byte-addressed data memory.
// Each access is IDLE (grant + check) -> ACCESS (memory strobe) -> RESP (ack).
module dmem_arbiter #(
  parameter int MEM_BYTES = 1024
) (
  input logic           clk,
  input logic           rst,
  dmem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

  state_t            state;
  logic              last_grant, gnt, gnt_q, lat_we, lat_err;
  logic              req_any, sel_we, sel_err;
  logic [31:0]       sel_addr, sel_wdata;
  logic [2:0]        sel_f3;
  logic [1:0]        ack_q, err_q;
  logic [1:0][31:0]  rdata_q;
  logic [31:0]       maddr_q, mwdata_q;
  logic              mwrite_q, mread_q;
  logic [2:0]        mf3_q;

  // Width code legality, natural alignment and range; the end address is
  // formed in 33 bits so accesses wrapping past 2^32 are rejected too.
  function automatic logic acc_err(input logic we, input logic [31:0] addr,
                                   input logic [2:0] f3);
    logic        bad_code, misal;
    logic [32:0] size, end_addr;
    bad_code = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 >= 3'd6);
    size     = (f3[1:0] == 2'd2) ? 33'd4 : (f3[1:0] == 2'd1) ? 33'd2 : 33'd1;
    misal    = (f3[1:0] == 2'd2 && addr[1:0] != 2'd0) ||
               (f3[1:0] == 2'd1 && addr[0]);
    end_addr = {1'b0, addr} + size;
    return bad_code | misal | (end_addr > 33'(MEM_BYTES));
  endfunction

  // Single requester wins; on a tie the port that did not win last time wins.
  assign req_any   = bus.p0_req | bus.p1_req;
  assign gnt       = bus.p1_req & (~bus.p0_req | ~last_grant);
  assign sel_we    = gnt ? bus.p1_we    : bus.p0_we;
  assign sel_addr  = gnt ? bus.p1_addr  : bus.p0_addr;
  assign sel_wdata = gnt ? bus.p1_wdata : bus.p0_wdata;
  assign sel_f3    = gnt ? bus.p1_func3 : bus.p0_func3;
  assign sel_err   = acc_err(sel_we, sel_addr, sel_f3);

  // Sequencer: all outputs are registers so mem_* is clean and the async
  // reset drops an in-flight strobe immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      gnt_q      <= 1'b0;
      lat_we     <= 1'b0;
      lat_err    <= 1'b0;
      ack_q      <= '0;
      err_q      <= '0;
      rdata_q    <= '0;
      maddr_q    <= '0;
      mwdata_q   <= '0;
      mwrite_q   <= 1'b0;
      mread_q    <= 1'b0;
      mf3_q      <= '0;
    end else begin
      case (state)
        IDLE: if (req_any) begin
          gnt_q      <= gnt;
          last_grant <= gnt;
          lat_we     <= sel_we;
          lat_err    <= sel_err;
          if (!sel_err) begin
            maddr_q  <= sel_addr;
            mwdata_q <= sel_wdata;
            mf3_q    <= sel_f3;
            mwrite_q <= sel_we;
            mread_q  <= ~sel_we;
          end
          state <= ACCESS;
        end
        ACCESS: begin
          maddr_q        <= '0;
          mwdata_q       <= '0;
          mf3_q          <= '0;
          mwrite_q       <= 1'b0;
          mread_q        <= 1'b0;
          ack_q[gnt_q]   <= 1'b1;
          err_q[gnt_q]   <= lat_err;
          rdata_q[gnt_q] <= (!lat_we && !lat_err) ? bus.mem_data_out : 32'h0;
          state          <= RESP;
        end
        RESP: begin
          ack_q <= '0;
          err_q <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.p0_ack         = ack_q[0];
  assign bus.p1_ack         = ack_q[1];
  assign bus.p0_err         = err_q[0];
  assign bus.p1_err         = err_q[1];
  assign bus.p0_rdata       = rdata_q[0];
  assign bus.p1_rdata       = rdata_q[1];
  assign bus.mem_addr       = maddr_q;
  assign bus.mem_write_data = mwdata_q;
  assign bus.mem_write      = mwrite_q;
  assign bus.mem_read       = mread_q;
  assign bus.mem_func3      = mf3_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: reset values, tie arbitration, a directed vector
// table, async reset mid-store, then random two-port traffic vs a model.
module tb_dmem_arbiter;
  localparam int MEM_BYTES = 1024;

  typedef struct {
    int          port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0, failures = 0;

  dmem_arbiter_if bif();
  dmem_arbiter #(.MEM_BYTES(MEM_BYTES)) dut (.clk(clk), .rst(rst), .bus(bif));

  always #5 clk = ~clk;

  // Memory behind the arbiter: combinational read with extension, write on edge.
  logic [7:0]  tbmem [0:1023] = '{default: 8'h00};
  logic [9:0]  ra;
  logic [31:0] rword;
  always_comb begin
    ra    = bif.mem_addr[9:0];
    rword = {tbmem[ra + 10'd3], tbmem[ra + 10'd2], tbmem[ra + 10'd1], tbmem[ra]};
    case (bif.mem_func3)
      3'd0:    bif.mem_data_out = {{24{rword[7]}}, rword[7:0]};
      3'd1:    bif.mem_data_out = {{16{rword[15]}}, rword[15:0]};
      3'd4:    bif.mem_data_out = {24'h0, rword[7:0]};
      3'd5:    bif.mem_data_out = {16'h0, rword[15:0]};
      default: bif.mem_data_out = rword;
    endcase
  end
  always @(posedge clk) if (bif.mem_write) begin
    tbmem[ra] <= bif.mem_write_data[7:0];
    if (bif.mem_func3[1:0] != 2'd0) tbmem[ra + 10'd1] <= bif.mem_write_data[15:8];
    if (bif.mem_func3[1:0] == 2'd2) begin
      tbmem[ra + 10'd2] <= bif.mem_write_data[23:16];
      tbmem[ra + 10'd3] <= bif.mem_write_data[31:24];
    end
  end

  // Transaction-level reference: byte array plus rule-based error/extension.
  int unsigned ref_mem [0:1023];

  function automatic int ref_size(input int f3);
    return (f3 % 4 == 2) ? 4 : (f3 % 4 == 1) ? 2 : 1;
  endfunction

  function automatic logic ref_err(input logic we, input logic [31:0] a, input int f3);
    longint unsigned last;
    if (we) begin
      if (f3 > 2) return 1'b1;
    end else if (!(f3 inside {0, 1, 2, 4, 5})) return 1'b1;
    if (a % ref_size(f3) != 0) return 1'b1;
    last = {32'd0, a} + 64'(ref_size(f3));
    return last > 64'(MEM_BYTES);
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input int f3);
    int unsigned v;
    int          i;
    i = int'(a);
    case (f3)
      0: begin v = ref_mem[i]; return (v >= 128) ? v - 256 : v; end
      4: return ref_mem[i];
      1: begin v = ref_mem[i] + 256 * ref_mem[i+1]; return (v >= 32768) ? v - 65536 : v; end
      5: return ref_mem[i] + 256 * ref_mem[i+1];
      default: return ref_mem[i] + 256 * ref_mem[i+1] + 65536 * ref_mem[i+2] + 16777216 * ref_mem[i+3];
    endcase
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [31:0] wd, input int f3);
    for (int k = 0; k < ref_size(f3); k++) ref_mem[int'(a) + k] = (wd >> (8 * k)) & 32'hFF;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_port(input int p, input logic req, input logic we, input logic [31:0] a,
                          input logic [31:0] wd, input logic [2:0] f3);
    if (p == 0) begin
      bif.p0_req = req; bif.p0_we = we; bif.p0_addr = a; bif.p0_wdata = wd; bif.p0_func3 = f3;
    end else begin
      bif.p1_req = req; bif.p1_we = we; bif.p1_addr = a; bif.p1_wdata = wd; bif.p1_func3 = f3;
    end
  endtask

  function automatic logic get_ack(input int p);
    return (p == 0) ? bif.p0_ack : bif.p1_ack;
  endfunction
  function automatic logic get_err(input int p);
    return (p == 0) ? bif.p0_err : bif.p1_err;
  endfunction
  function automatic logic [31:0] get_rdata(input int p);
    return (p == 0) ? bif.p0_rdata : bif.p1_rdata;
  endfunction

  // One isolated transaction on port p, observed at negedges; bounded wait.
  task automatic txn(input int p, input logic we, input logic [31:0] a, input logic [31:0] wd,
                     input logic [2:0] f3, output int lat, output logic e, output logic [31:0] rd,
                     output int nwr, output int nrd, output logic [31:0] sa);
    lat = -1; e = 1'b0; rd = 32'h0; nwr = 0; nrd = 0; sa = 32'h0;
    @(negedge clk);
    set_port(p, 1'b1, we, a, wd, f3);
    for (int c = 1; c <= 10 && lat < 0; c++) begin
      @(negedge clk);
      if (bif.mem_write) nwr++;
      if (bif.mem_read) nrd++;
      if (bif.mem_write || bif.mem_read) sa = bif.mem_addr;
      if (get_ack(p)) begin lat = c; e = get_err(p); rd = get_rdata(p); end
    end
    set_port(p, 1'b0, 1'b0, 32'h0, 32'h0, 3'h0);
  endtask

  vec_t        vt[$];
  int          lat, nwr, nrd, nack, n;
  logic        e;
  logic [31:0] rd, sa;
  int          ack_port [4];
  int          ack_cyc  [4];
  logic        busy [2];
  int          age  [2];
  logic        t_we [2];
  logic [31:0] t_addr [2];
  logic [31:0] t_wd [2];
  logic [2:0]  t_f3 [2];
  logic        ack_now [2];
  int          last_ack;
  logic        exp_e;
  logic [31:0] exp_rd;

  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = 0;
    set_port(0, 1'b0, 1'b0, 32'h0, 32'h0, 3'h0);
    set_port(1, 1'b0, 1'b0, 32'h0, 32'h0, 3'h0);
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_p0_ack", bif.p0_ack, 0);
    chk("rst_p1_ack", bif.p1_ack, 0);
    chk("rst_p0_err", bif.p0_err, 0);
    chk("rst_p1_err", bif.p1_err, 0);
    chk("rst_p0_rdata", bif.p0_rdata, 0);
    chk("rst_p1_rdata", bif.p1_rdata, 0);
    chk("rst_mem_write", bif.mem_write, 0);
    chk("rst_mem_read", bif.mem_read, 0);
    chk("rst_mem_addr", bif.mem_addr, 0);
    rst = 1'b0;

    // Both ports held high straight out of reset: grants 0,1,0,1, 3 cycles apart
    for (int i = 0; i < 4; i++) begin ack_port[i] = -1; ack_cyc[i] = -1; end
    set_port(0, 1'b1, 1'b0, 32'h0, 32'h0, 3'd2);
    set_port(1, 1'b1, 1'b0, 32'h4, 32'h0, 3'd2);
    nack = 0;
    for (int c = 1; c <= 20 && nack < 4; c++) begin
      @(negedge clk);
      if (bif.p0_ack || bif.p1_ack) begin
        chk("arb_ack_overlap", bif.p0_ack & bif.p1_ack, 0);
        ack_port[nack] = bif.p1_ack ? 1 : 0;
        ack_cyc[nack]  = c;
        nack++;
      end
    end
    set_port(0, 1'b0, 1'b0, 32'h0, 32'h0, 3'h0);
    set_port(1, 1'b0, 1'b0, 32'h0, 32'h0, 3'h0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("arb_port%0d", i), ack_port[i], i % 2);
      chk($sformatf("arb_cyc%0d", i), ack_cyc[i], 2 + 3 * i);
    end

    // Directed vectors: port, we, addr, wdata, func3, err, rdata
    vt.push_back('{0, 1'b1, 32'h10,       32'hDEADBEEF, 3'd2, 1'b0, 32'h0});
    vt.push_back('{0, 1'b0, 32'h10,       32'h0,        3'd2, 1'b0, 32'hDEADBEEF});
    vt.push_back('{0, 1'b1, 32'h20,       32'h00000080, 3'd0, 1'b0, 32'h0});
    vt.push_back('{1, 1'b0, 32'h20,       32'h0,        3'd0, 1'b0, 32'hFFFFFF80});
    vt.push_back('{0, 1'b0, 32'h20,       32'h0,        3'd4, 1'b0, 32'h00000080});
    vt.push_back('{1, 1'b1, 32'h22,       32'h00008001, 3'd1, 1'b0, 32'h0});
    vt.push_back('{0, 1'b0, 32'h22,       32'h0,        3'd1, 1'b0, 32'hFFFF8001});
    vt.push_back('{1, 1'b0, 32'h22,       32'h0,        3'd5, 1'b0, 32'h00008001});
    vt.push_back('{0, 1'b0, 32'h12,       32'h0,        3'd2, 1'b1, 32'h0});
    vt.push_back('{1, 1'b1, 32'h3FE,      32'h11223344, 3'd2, 1'b1, 32'h0});
    vt.push_back('{0, 1'b0, 32'h0,        32'h0,        3'd3, 1'b1, 32'h0});
    vt.push_back('{1, 1'b1, 32'hFFFFFFFC, 32'h55667788, 3'd2, 1'b1, 32'h0});
    vt.push_back('{0, 1'b0, 32'h3FC,      32'h0,        3'd2, 1'b0, 32'h0});
    vt.push_back('{1, 1'b1, 32'h3FF,      32'h000000AB, 3'd0, 1'b0, 32'h0});
    vt.push_back('{0, 1'b0, 32'h3FF,      32'h0,        3'd4, 1'b0, 32'h000000AB});
    vt.push_back('{1, 1'b0, 32'h3FF,      32'h0,        3'd1, 1'b1, 32'h0});
    vt.push_back('{0, 1'b1, 32'h30,       32'h0,        3'd4, 1'b1, 32'h0});
    foreach (vt[i]) begin
      txn(vt[i].port, vt[i].we, vt[i].addr, vt[i].wdata, vt[i].f3, lat, e, rd, nwr, nrd, sa);
      chk($sformatf("v%0d_latency", i), lat, 2);
      chk($sformatf("v%0d_err", i), e, vt[i].err);
      chk($sformatf("v%0d_rdata", i), rd, vt[i].rdata);
      chk($sformatf("v%0d_nwrite", i), nwr, (vt[i].we && !vt[i].err) ? 1 : 0);
      chk($sformatf("v%0d_nread", i), nrd, (!vt[i].we && !vt[i].err) ? 1 : 0);
      if (!vt[i].err) begin
        chk($sformatf("v%0d_mem_addr", i), sa, vt[i].addr);
        if (vt[i].we) ref_store(vt[i].addr, vt[i].wdata, int'(vt[i].f3));
      end
    end

    // Reset during the ACCESS cycle of a port-1 store
    @(negedge clk);
    set_port(1, 1'b1, 1'b1, 32'h40, 32'h12345678, 3'd2);
    @(negedge clk);
    chk("midrst_write_before", bif.mem_write, 1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_write_async", bif.mem_write, 0);
    chk("midrst_addr_async", bif.mem_addr, 0);
    set_port(1, 1'b0, 1'b0, 32'h0, 32'h0, 3'h0);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    repeat (4) begin
      @(negedge clk);
      if (bif.p0_ack || bif.p1_ack) n++;
    end
    chk("midrst_no_ack", n, 0);
    txn(0, 1'b0, 32'h10, 32'h0, 3'd2, lat, e, rd, nwr, nrd, sa);
    chk("midrst_p0_latency", lat, 2);
    chk("midrst_p0_err", e, 0);
    chk("midrst_p0_rdata", rd, 32'hDEADBEEF);

    // Random two-port traffic checked against the reference model
    for (int p = 0; p < 2; p++) begin busy[p] = 1'b0; age[p] = 0; end
    last_ack = -10;
    for (int cyc = 0; cyc < 800; cyc++) begin
      @(negedge clk);
      if (bif.mem_write || bif.mem_read) chk("rnd_strobe_excl", bif.mem_write & bif.mem_read, 0);
      if (bif.p0_ack || bif.p1_ack) begin
        chk("rnd_ack_overlap", bif.p0_ack & bif.p1_ack, 0);
        chk("rnd_ack_gap", (cyc - last_ack) >= 3, 1);
        last_ack = cyc;
      end
      for (int p = 0; p < 2; p++) if (busy[p]) age[p]++;
      for (int p = 0; p < 2; p++) begin
        ack_now[p] = get_ack(p);
        if (ack_now[p]) begin
          chk($sformatf("rnd_p%0d_ack_busy", p), busy[p], 1);
          if (busy[p]) begin
            exp_e  = ref_err(t_we[p], t_addr[p], int'(t_f3[p]));
            exp_rd = (!exp_e && !t_we[p]) ? ref_load(t_addr[p], int'(t_f3[p])) : 32'h0;
            if (!exp_e && t_we[p]) ref_store(t_addr[p], t_wd[p], int'(t_f3[p]));
            chk($sformatf("rnd_p%0d_err a=%h f=%0d", p, t_addr[p], t_f3[p]), get_err(p), exp_e);
            chk($sformatf("rnd_p%0d_rdata a=%h f=%0d", p, t_addr[p], t_f3[p]), get_rdata(p), exp_rd);
            chk($sformatf("rnd_p%0d_wait_le5", p), (age[p] >= 2 && age[p] <= 5), 1);
            busy[p] = 1'b0;
            set_port(p, 1'b0, 1'b0, 32'h0, 32'h0, 3'h0);
          end
        end
      end
      for (int p = 0; p < 2; p++) begin
        if (!busy[p] && !ack_now[p] && cyc < 700 && $urandom_range(0, 2) == 0) begin
          t_we[p] = 1'($urandom_range(0, 1));
          case ($urandom_range(0, 9))
            7:       t_addr[p] = 32'h3F8 + $urandom_range(0, 7);
            8:       t_addr[p] = 32'hFFFFFFF8 + $urandom_range(0, 7);
            9:       t_addr[p] = $urandom;
            default: t_addr[p] = 32'h100 + 4 * $urandom_range(0, 15) +
                                 (($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : 0);
          endcase
          if ($urandom_range(0, 3) == 0) t_f3[p] = 3'($urandom_range(0, 7));
          else if (t_we[p]) t_f3[p] = 3'($urandom_range(0, 2));
          else begin
            n = $urandom_range(0, 4);
            t_f3[p] = 3'((n > 2) ? n + 1 : n);
          end
          t_wd[p] = $urandom;
          busy[p] = 1'b1;
          age[p]  = 0;
          set_port(p, 1'b1, t_we[p], t_addr[p], t_wd[p], t_f3[p]);
        end
      end
    end
    for (int p = 0; p < 2; p++) chk($sformatf("rnd_p%0d_drained", p), busy[p], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
